cd_tx_loader: RTL

- Upstream feeder for the CDBUS TX path.
- Accepts one frame as a byte stream and packs the bytes into 32-bit words on the tx_mm port of the cdbus top.
- Polls the CSR status register until the TX page is free, then writes the TX-switch command so the frame is transmitted.
- One loader drives one cdbus instance. It is the only master on that instance's tx_mm and CSR ports.

---
 rtl/cd_tx_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/cd_tx_loader.sv
// Purpose : packs a byte-stream frame into 32-bit words on the cdbus tx_mm port, polls the
//           CSR status until the TX page is free, then issues the TX-switch command.
// Latency : a word is written one cycle after its last byte is accepted. The first status read
//           comes in that same cycle. Reads repeat every POLL_GAP+2 cycles while the page is busy.
// Backpr. : s_ready is high in IDLE/FILL/DISCARD (one byte per cycle there) and low while polling or switching.
// Ports   : clk/reset_n (async active-low); s_data/s_valid/s_last/s_ready byte stream; abort cancels the frame;
//           csr_* single-master CSR port; tx_mm_* TX page write port; busy/frame_done/frame_drop status.
module cd_tx_loader #(
   parameter logic [3:0] CSR_STATUS_ADDR       = 4'd4,
   parameter logic [3:0] CSR_CMD_ADDR          = 4'd5,
   parameter int         STATUS_TX_PENDING_BIT = 5,
   parameter int         CMD_TX_SWITCH_BIT     = 1,
   parameter int         POLL_GAP              = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        abort,
   output logic [3:0]  csr_address,
   output logic        csr_read,
   input  logic [31:0] csr_readdata,
   output logic        csr_write,
   output logic [31:0] csr_writedata,
   output logic [3:0]  csr_byteenable,
   output logic [5:0]  tx_mm_address,
   output logic        tx_mm_write,
   output logic [31:0] tx_mm_writedata,
   output logic [3:0]  tx_mm_byteenable,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_drop
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      DISCARD = 3'd2,
      POLL    = 3'd3,
      RDWAIT  = 3'd4,
      GAP     = 3'd5,
      SWITCH  = 3'd6
   } state_t;

   localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);
   localparam logic [31:0] SWITCH_CMD = 32'd1 << CMD_TX_SWITCH_BIT;

   state_t      state;
   state_t      state_nxt;
   logic [8:0]  byte_cnt;
   logic [31:0] word_buf;
   logic [3:0]  lane_be;
   logic [7:0]  gap_cnt;

   logic        byte_acc;
   logic        byte_take;
   logic        word_wr;
   logic        drop_pulse;
   logic [1:0]  lane;
   logic [31:0] word_merged;
   logic [3:0]  be_merged;

   assign s_ready    = (state == IDLE) || (state == FILL) || (state == DISCARD);
   assign busy       = (state != IDLE);
   assign frame_drop = drop_pulse;

   assign byte_acc = s_valid && s_ready;
   assign lane     = byte_cnt[1:0];

   // Bytes past the 256-byte page (byte_cnt[8] set) are never stored.
   // In IDLE an abort wins over the incoming byte. In FILL the byte is still stored.
   assign byte_take = byte_acc && !byte_cnt[8] &&
                      ((state == FILL) || ((state == IDLE) && !abort));
   assign word_wr   = byte_take && ((lane == 2'd3) || s_last);

   always_comb begin
      word_merged = word_buf;
      word_merged[{lane, 3'b000} +: 8] = s_data;
      be_merged = lane_be | (4'b0001 << lane);
   end

   // Next-state logic. frame_drop is a Mealy pulse in the cycle that ends the frame,
   // so the following cycle is always IDLE (busy low).
   always_comb begin
      state_nxt  = state;
      drop_pulse = 1'b0;
      case (state)
         IDLE: begin
            if (byte_acc) begin
               if (abort) begin
                  state_nxt  = s_last ? IDLE : DISCARD;
                  drop_pulse = s_last;
               end else begin
                  state_nxt = s_last ? POLL : FILL;
               end
            end
         end
         FILL: begin
            if (byte_acc && (abort || byte_cnt[8])) begin
               state_nxt  = s_last ? IDLE : DISCARD;
               drop_pulse = s_last;
            end else if (abort) begin
               state_nxt = DISCARD;
            end else if (byte_acc && s_last) begin
               state_nxt = POLL;
            end
         end
         DISCARD: begin
            if (byte_acc && s_last) begin
               state_nxt  = IDLE;
               drop_pulse = 1'b1;
            end
         end
         POLL: begin
            if (abort) begin
               state_nxt  = IDLE;
               drop_pulse = 1'b1;
            end else begin
               state_nxt = RDWAIT;
            end
         end
         RDWAIT: begin
            if (abort) begin
               state_nxt  = IDLE;
               drop_pulse = 1'b1;
            end else if (csr_readdata[STATUS_TX_PENDING_BIT]) begin
               state_nxt = GAP;
            end else begin
               state_nxt = SWITCH;
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt  = IDLE;
               drop_pulse = 1'b1;
            end else if (gap_cnt == GAP_LAST) begin
               state_nxt = POLL;
            end
         end
         SWITCH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Byte counter and lane accumulator. The frame context is cleared whenever the frame
   // ends or is being discarded, so the next frame always starts at word 0, lane 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt <= 9'd0;
         word_buf <= 32'd0;
         lane_be  <= 4'd0;
         gap_cnt  <= 8'd0;
      end else begin
         gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
         if ((state_nxt == IDLE) || (state_nxt == DISCARD)) begin
            byte_cnt <= 9'd0;
            word_buf <= 32'd0;
            lane_be  <= 4'd0;
         end else if (byte_take) begin
            byte_cnt <= byte_cnt + 9'd1;
            word_buf <= word_wr ? 32'd0 : word_merged;
            lane_be  <= word_wr ? 4'd0 : be_merged;
         end
      end
   end

   // TX page write port: loads on the same edge that clears the accumulator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_mm_write      <= 1'b0;
         tx_mm_address    <= 6'd0;
         tx_mm_writedata  <= 32'd0;
         tx_mm_byteenable <= 4'd0;
      end else begin
         tx_mm_write <= word_wr;
         if (word_wr) begin
            tx_mm_address    <= byte_cnt[7:2];
            tx_mm_writedata  <= word_merged;
            tx_mm_byteenable <= be_merged;
         end
      end
   end

   // CSR strobes are registered from the next state, so they line up with POLL / SWITCH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csr_read       <= 1'b0;
         csr_write      <= 1'b0;
         csr_address    <= 4'd0;
         csr_writedata  <= 32'd0;
         csr_byteenable <= 4'd0;
         frame_done     <= 1'b0;
      end else begin
         csr_read       <= (state_nxt == POLL);
         csr_write      <= (state_nxt == SWITCH);
         frame_done     <= (state_nxt == SWITCH);
         csr_address    <= (state_nxt == POLL)   ? CSR_STATUS_ADDR :
                           (state_nxt == SWITCH) ? CSR_CMD_ADDR : 4'd0;
         csr_writedata  <= (state_nxt == SWITCH) ? SWITCH_CMD : 32'd0;
         csr_byteenable <= (state_nxt == SWITCH) ? 4'hf : 4'd0;
      end
   end

endmodule
